// File: rtl/post_mux_counter_bank_if.sv
// Measurement-race handshake and result bus between the RO PUF sequencer
// and the post-mux counter bank.
interface post_mux_counter_bank_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 22
);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      start;
    logic [CHANNELS-1:0]       enable;
    logic                      busy;
    logic                      done;
    logic [IDX_W-1:0]          winner;
    logic                      tie;
    logic                      timeout;
    logic [CHANNELS*WIDTH-1:0] count;

    modport master (
        output start, enable,
        input  busy, done, winner, tie, timeout, count
    );

    modport slave (
        input  start, enable,
        output busy, done, winner, tie, timeout, count
    );
endinterface

// File: rtl/post_mux_counter_bank.sv
// Multi-channel post-mux counter bank: races CHANNELS counters to 2^GOAL_BIT
// and reports winner, tie, timeout and all final counts until the next start.
module post_mux_counter_bank #(
    parameter int CHANNELS       = 2,
    parameter int WIDTH          = 22,
    parameter int GOAL_BIT       = WIDTH - 1,
    parameter int TIMEOUT_CYCLES = 2 ** 24
) (
    input  logic                     clk,
    input  logic                     reset,
    post_mux_counter_bank_if.slave   bus
);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CYC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WIDTH-1:0] GOAL = {{(WIDTH-1){1'b0}}, 1'b1} << GOAL_BIT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]    cnt_q    [CHANNELS];
    logic [WIDTH-1:0]    cnt_next [CHANNELS];
    logic [CHANNELS-1:0] hit;
    logic [CYC_W-1:0]    cyc_q;
    logic [IDX_W-1:0]    winner_q;
    logic                tie_q;
    logic                timeout_q;

    logic [IDX_W-1:0]    low_idx;
    logic                any_hit;
    logic                multi_hit;
    logic                cyc_expired;
    int                  n_hits;

    // Goal detection looks at the value each counter is about to take, so the
    // winner's latched count is exactly the goal.
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        low_idx = '0;
        n_hits  = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_next[i] = cnt_q[i] + {{(WIDTH-1){1'b0}}, bus.enable[i]};
            hit[i]      = (cnt_next[i] == GOAL);
            n_hits      = n_hits + int'(hit[i]);
        end
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (hit[i]) low_idx = IDX_W'(i);
        end
        any_hit     = (n_hits > 0);
        multi_hit   = (n_hits > 1);
        cyc_expired = (cyc_q == CYC_W'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (any_hit || cyc_expired) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            winner_q  <= '0;
            tie_q     <= 1'b0;
            timeout_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cyc_q     <= '0;
                        winner_q  <= '0;
                        tie_q     <= 1'b0;
                        timeout_q <= 1'b0;
                        for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
                    end
                end
                RUN: begin
                    cyc_q <= cyc_q + CYC_W'(1);
                    if (any_hit) begin
                        winner_q  <= low_idx;
                        tie_q     <= multi_hit;
                        timeout_q <= 1'b0;
                        for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_next[i];
                    end else if (cyc_expired) begin
                        // Abort: counts freeze at their pre-edge values.
                        winner_q  <= '0;
                        tie_q     <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_next[i];
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches them combinationally.
    always_comb begin
        bus.busy    = (state_q != IDLE);
        bus.done    = (state_q == DONE);
        bus.winner  = winner_q;
        bus.tie     = tie_q;
        bus.timeout = timeout_q;
        bus.count   = '0;
        for (int i = 0; i < CHANNELS; i++) bus.count[i*WIDTH +: WIDTH] = cnt_q[i];
    end
endmodule

// File: tb/tb_post_mux_counter_bank.sv
// Scoreboard bench for post_mux_counter_bank: three small configurations
// (2ch/T=8, 4ch/T=64, 2ch/T=4 goal-timeout collision), GOAL_BIT=2.
module tb_post_mux_counter_bank;
    localparam int GOAL = 4;
    localparam int NCH [3] = '{2, 4, 2};
    localparam int TMO [3] = '{8, 64, 4};

    typedef struct {
        string       tag;
        logic [1:0]  winner;
        logic        tie;
        logic        tmo;
        logic [15:0] count;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start_v [3];
    logic [3:0]  en_v    [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        tie_v   [3];
    logic        to_v    [3];
    logic [1:0]  win_v   [3];
    logic [15:0] cnt_v   [3];

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    post_mux_counter_bank_if #(.CHANNELS(2), .WIDTH(4)) if_a ();
    post_mux_counter_bank_if #(.CHANNELS(4), .WIDTH(4)) if_b ();
    post_mux_counter_bank_if #(.CHANNELS(2), .WIDTH(4)) if_c ();

    post_mux_counter_bank #(.CHANNELS(2), .WIDTH(4), .GOAL_BIT(2), .TIMEOUT_CYCLES(8))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    post_mux_counter_bank #(.CHANNELS(4), .WIDTH(4), .GOAL_BIT(2), .TIMEOUT_CYCLES(64))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    post_mux_counter_bank #(.CHANNELS(2), .WIDTH(4), .GOAL_BIT(2), .TIMEOUT_CYCLES(4))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));

    assign if_a.start  = start_v[0];
    assign if_a.enable = en_v[0][1:0];
    assign if_b.start  = start_v[1];
    assign if_b.enable = en_v[1];
    assign if_c.start  = start_v[2];
    assign if_c.enable = en_v[2][1:0];

    assign busy_v[0] = if_a.busy;  assign done_v[0] = if_a.done;
    assign tie_v[0]  = if_a.tie;   assign to_v[0]   = if_a.timeout;
    assign win_v[0]  = {1'b0, if_a.winner};
    assign cnt_v[0]  = {8'h00, if_a.count};
    assign busy_v[1] = if_b.busy;  assign done_v[1] = if_b.done;
    assign tie_v[1]  = if_b.tie;   assign to_v[1]   = if_b.timeout;
    assign win_v[1]  = if_b.winner;
    assign cnt_v[1]  = if_b.count;
    assign busy_v[2] = if_c.busy;  assign done_v[2] = if_c.done;
    assign tie_v[2]  = if_c.tie;   assign to_v[2]   = if_c.timeout;
    assign win_v[2]  = {1'b0, if_c.winner};
    assign cnt_v[2]  = {8'h00, if_c.count};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: with enable held constant, channel i has k counts after k
    // RUN edges; the goal lands at edge 2^GOAL_BIT, the timeout at edge T.
    function automatic exp_t model(input int sel, input logic [3:0] en, input string tag);
        exp_t e;
        int   k;
        e.tag    = tag;
        e.winner = '0;
        e.tie    = 1'b0;
        e.count  = '0;
        if (en != 4'b0 && GOAL <= TMO[sel]) begin
            e.lat = GOAL;
            e.tmo = 1'b0;
            e.tie = ($countones(en) > 1);
            for (int i = 3; i >= 0; i--) if (en[i]) e.winner = 2'(i);
            k = GOAL;
        end else begin
            e.lat = TMO[sel];
            e.tmo = 1'b1;
            k = TMO[sel] - 1;
        end
        for (int i = 0; i < NCH[sel]; i++) if (en[i]) e.count[i*4 +: 4] = 4'(k);
        return e;
    endfunction

    // Called at a negedge; drives start for the next edge and scores the race.
    task automatic race(input int sel, input logic [3:0] en, input string tag, input bit poke);
        exp_t       e;
        int         k;
        bit         seen;
        logic [15:0] held;
        sb.push_back(model(sel, en, tag));
        en_v[sel]    = en;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        check({tag, "_busy_start"}, 32'(busy_v[sel]), 32'd1);
        check({tag, "_cleared"}, 32'(cnt_v[sel]), 32'd0);
        k    = 0;
        seen = 1'b0;
        while (k < 100 && !seen) begin
            @(negedge clk);
            k++;
            if (done_v[sel]) seen = 1'b1;
        end
        e = sb.pop_front();
        if (!seen) begin
            check({e.tag, "_no_done"}, 32'd0, 32'd1);
            en_v[sel] = '0;
            return;
        end
        check({e.tag, "_latency"}, 32'(k), 32'(e.lat));
        check({e.tag, "_winner"}, 32'(win_v[sel]), 32'(e.winner));
        check({e.tag, "_tie"}, 32'(tie_v[sel]), 32'(e.tie));
        check({e.tag, "_timeout"}, 32'(to_v[sel]), 32'(e.tmo));
        check({e.tag, "_count"}, 32'(cnt_v[sel]), 32'(e.count));
        check({e.tag, "_busy_done"}, 32'(busy_v[sel]), 32'd1);
        held = e.count;
        if (poke) start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        en_v[sel]    = '0;
        check({e.tag, "_done_pulse"}, 32'(done_v[sel]), 32'd0);
        check({e.tag, "_busy_idle"}, 32'(busy_v[sel]), 32'd0);
        check({e.tag, "_count_hold"}, 32'(cnt_v[sel]), 32'(held));
    endtask

    initial begin
        bit done_seen;
        reset = 1'b1;
        for (int s = 0; s < 3; s++) begin
            start_v[s] = 1'b0;
            en_v[s]    = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst%0d_busy", s), 32'(busy_v[s]), 32'd0);
            check($sformatf("rst%0d_done", s), 32'(done_v[s]), 32'd0);
            check($sformatf("rst%0d_flags", s), {29'd0, win_v[s], tie_v[s] | to_v[s]}, 32'd0);
            check($sformatf("rst%0d_count", s), 32'(cnt_v[s]), 32'd0);
        end

        // Enable without start: nothing counts.
        en_v[0]   = 4'b0011;
        done_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) done_seen = 1'b1;
        end
        en_v[0] = '0;
        check("idle_no_activity", 32'(done_seen), 32'd0);
        check("idle_count", 32'(cnt_v[0]), 32'd0);

        race(0, 4'b0010, "single", 1'b1);   // start poked during DONE
        race(0, 4'b0000, "timeout", 1'b0);  // issued in the first IDLE cycle
        race(1, 4'b1010, "tie", 1'b0);
        race(1, 4'b0100, "ch2", 1'b0);
        race(1, 4'b1111, "tie_all", 1'b0);
        race(2, 4'b0001, "collide", 1'b0);
        race(2, 4'b0000, "c_timeout", 1'b0);
        race(2, 4'b0010, "c_ch1", 1'b0);

        // Reset mid-RUN after two increments.
        en_v[0]    = 4'b0001;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_pre_reset_count", 32'(cnt_v[0]), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_busy", 32'(busy_v[0]), 32'd0);
        check("mid_count", 32'(cnt_v[0]), 32'd0);
        check("mid_flags", {29'd0, win_v[0], tie_v[0] | to_v[0]}, 32'd0);
        done_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[0]) done_seen = 1'b1;
        end
        en_v[0] = '0;
        check("mid_no_done", 32'(done_seen), 32'd0);
        check("mid_count_after", 32'(cnt_v[0]), 32'd0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
